// File: rtl/multicycle_controller_pkg.sv
// Shared controller constants: FSM states, MIPS opcode/func codes, ALU codes and
// datapath mux encodings, plus the R-type func -> ALU operation map.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_4      = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] SH_NONE  = 2'd0;
  localparam logic [1:0] SH_SHAMT = 2'd1;
  localparam logic [1:0] SH_LUI   = 2'd2;

  localparam logic [1:0] BR_BEQ  = 2'd0;
  localparam logic [1:0] BR_BNE  = 2'd1;
  localparam logic [1:0] BR_BGTZ = 2'd2;
  localparam logic [1:0] BR_BGEZ = 2'd3;

  // Same func map as the single-cycle decoder; ALU_NOP marks an unsupported func.
  function automatic logic [3:0] func_aluop(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU: return ALU_ADD;
      F_SUB, F_SUBU: return ALU_SUB;
      F_AND:         return ALU_AND;
      F_OR:          return ALU_OR;
      F_XOR:         return ALU_XOR;
      F_NOR:         return ALU_NOR;
      F_SLT:         return ALU_SLT;
      F_SLTU:        return ALU_SLTU;
      F_SLL:         return ALU_SLL;
      F_SRL:         return ALU_SRL;
      F_SRA:         return ALU_SRA;
      default:       return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR fields and mem_ready in, control strobes out.
interface multicycle_controller_if #(parameter int ALUOP_W = 4);
  logic [5:0]         opcode;
  logic [5:0]         func;
  logic [4:0]         rt;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_write;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_src;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         shift;
  logic [1:0]         branch_type;
  logic [1:0]         regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               illegal;
  logic               bus_err;

  modport master (
    input  opcode, func, rt, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alusrca, alusrcb, aluop, shift, branch_type, regdst, memtoreg,
           regwrite, illegal, bus_err
  );

  modport slave (
    output opcode, func, rt, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alusrca, alusrcb, aluop, shift, branch_type, regdst, memtoreg,
           regwrite, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_controller_alu_decode.sv
// ALU operation and shift mode from FSM state plus the opcode/func latched in DECODE.
module multicycle_controller_alu_decode
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  state_t             i_state,
  input  logic [5:0]         i_op,
  input  logic [5:0]         i_func,
  output logic [ALUOP_W-1:0] o_aluop,
  output logic [1:0]         o_shift
);

  always_comb begin
    o_aluop = ALUOP_W'(ALU_NOP);
    o_shift = SH_NONE;
    case (i_state)
      S_FETCH, S_DECODE, S_MEM_ADDR: o_aluop = ALUOP_W'(ALU_ADD);
      S_BRANCH:                      o_aluop = ALUOP_W'(ALU_SUB);
      S_EXEC_R: begin
        o_aluop = ALUOP_W'(func_aluop(i_func));
        if (i_func == F_SLL || i_func == F_SRL || i_func == F_SRA) o_shift = SH_SHAMT;
      end
      S_EXEC_I: begin
        case (i_op)
          OP_ADDI, OP_ADDIU: o_aluop = ALUOP_W'(ALU_ADD);
          OP_ANDI:           o_aluop = ALUOP_W'(ALU_AND);
          OP_ORI:            o_aluop = ALUOP_W'(ALU_OR);
          OP_SLTI:           o_aluop = ALUOP_W'(ALU_SLT);
          OP_LUI: begin
            o_aluop = ALUOP_W'(ALU_SLL);
            o_shift = SH_LUI;
          end
          default:           o_aluop = ALUOP_W'(ALU_NOP);
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with
// a shared-memory handshake, optional memory timeout and sticky trap flags.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_JUMP     = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             r_state, w_next, w_dec;
  logic [5:0]         r_op, r_func;
  logic [4:0]         r_rt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_illegal, r_bus_err;
  logic               w_wait, w_tmo, w_set_ill, w_set_be;
  logic [ALUOP_W-1:0] w_aluop;
  logic [1:0]         w_shift;

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // mem_ready in the timeout cycle wins, so the timeout is qualified by !mem_ready.
  assign w_tmo  = (MEM_TIMEOUT != 0) && w_wait && !bus.mem_ready &&
                  (r_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_func    <= '0;
      r_rt      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op   <= bus.opcode;
        r_func <= bus.func;
        r_rt   <= bus.rt;
      end
      if (w_next != r_state)                                     r_cnt <= '0;
      else if (w_wait && !bus.mem_ready && (MEM_TIMEOUT != 0))   r_cnt <= r_cnt + 1'b1;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_be)  r_bus_err <= 1'b1;
    end
  end

  // Decode uses the live IR fields; the latched copies are only valid from the next state on.
  always_comb begin
    w_dec = S_TRAP;
    case (bus.opcode)
      OP_RTYPE: begin
        if (bus.func == F_JR)                        w_dec = S_JR;
        else if (func_aluop(bus.func) != ALU_NOP)    w_dec = S_EXEC_R;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: w_dec = S_EXEC_I;
      OP_LW, OP_SW:                                        w_dec = S_MEM_ADDR;
      OP_BEQ, OP_BNE, OP_BGTZ:                             w_dec = S_BRANCH;
      OP_REGIMM: if (bus.rt == RT_BGEZ)                    w_dec = S_BRANCH;
      OP_J, OP_JAL: if (EN_JUMP)                           w_dec = S_JUMP;
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_be  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          w_next = (r_state == S_FETCH)  ? S_DECODE :
                   (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (w_tmo) begin
          w_next   = S_TRAP;
          w_set_be = 1'b1;
        end
      end
      S_DECODE: begin
        w_next    = w_dec;
        w_set_ill = (w_dec == S_TRAP);
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_MEM_ADDR:         w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: w_next = S_FETCH;
      S_TRAP:             w_next = S_TRAP;
      default:            w_next = S_IDLE;
    endcase
  end

  multicycle_controller_alu_decode #(.ALUOP_W(ALUOP_W)) u_alu_dec (
    .i_state (r_state),
    .i_op    (r_op),
    .i_func  (r_func),
    .o_aluop (w_aluop),
    .o_shift (w_shift)
  );

  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = PCSRC_ALU;
    bus.alusrca       = 1'b0;
    bus.alusrcb       = ALUB_RT;
    bus.aluop         = w_aluop;
    bus.shift         = w_shift;
    bus.branch_type   = BR_BEQ;
    bus.regdst        = REGDST_RT;
    bus.memtoreg      = 1'b0;
    bus.regwrite      = 1'b0;
    bus.illegal       = r_illegal;
    bus.bus_err       = r_bus_err;
    case (r_state)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.alusrcb  = ALUB_4;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_DECODE: bus.alusrcb = ALUB_IMM_SH;
      S_EXEC_R: bus.alusrca = 1'b1;
      S_EXEC_I, S_MEM_ADDR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = ALUB_IMM;
      end
      S_WB_ALU: begin
        bus.regwrite = 1'b1;
        bus.regdst   = (r_op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
      end
      S_MEM_RD, S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = (r_state == S_MEM_WR);
      end
      S_WB_MEM: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca       = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PCSRC_ALUOUT;
        case (r_op)
          OP_BNE:    bus.branch_type = BR_BNE;
          OP_BGTZ:   bus.branch_type = BR_BGTZ;
          OP_REGIMM: bus.branch_type = (r_rt == RT_BGEZ) ? BR_BGEZ : BR_BEQ;
          default:   bus.branch_type = BR_BEQ;
        endcase
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PCSRC_JUMP;
        if (r_op == OP_JAL) begin
          bus.regwrite = 1'b1;
          bus.regdst   = REGDST_RA;
        end
      end
      S_JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PCSRC_RS;
      end
      default: ;
    endcase
  end

endmodule
